// File: rtl/vga_pixel_pipeline.sv
// Pixel pipeline behind the VGA timing counter: 2x-scaled frame-buffer fetch,
// palette lookup to 24-bit RGB, pipeline-aligned syncs and a vblank-start pulse.
module vga_pixel_pipeline #(
  parameter int unsigned PIXEL_BITWIDTH = 11,
  parameter int unsigned H_SYNC_START   = 656,
  parameter int unsigned H_SYNC_END     = 752,
  parameter int unsigned V_SYNC_START   = 490,
  parameter int unsigned V_SYNC_END     = 492,
  parameter logic        SYNC_ACTIVE    = 1'b0,
  parameter int unsigned X_OFFSET       = 64,
  parameter int unsigned HEIGHT_VISIBLE = 480,
  parameter logic [5:0]  BORDER_INDEX   = 6'h0F
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [PIXEL_BITWIDTH-1:0] i_x,
  input  logic [PIXEL_BITWIDTH-1:0] i_y,
  input  logic                      i_visible,
  output logic [15:0]               o_fb_addr,
  output logic                      o_fb_rd,
  input  logic [5:0]                i_fb_data,
  input  logic                      i_pal_we,
  input  logic [5:0]                i_pal_addr,
  input  logic [23:0]               i_pal_data,
  output logic [7:0]                o_r,
  output logic [7:0]                o_g,
  output logic [7:0]                o_b,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic                      o_vblank_start
);

  localparam logic [PIXEL_BITWIDTH-1:0] X_LO  = PIXEL_BITWIDTH'(X_OFFSET);
  localparam logic [PIXEL_BITWIDTH-1:0] X_HI  = PIXEL_BITWIDTH'(X_OFFSET + 512);
  localparam logic [PIXEL_BITWIDTH-1:0] Y_VIS = PIXEL_BITWIDTH'(HEIGHT_VISIBLE);
  localparam logic [PIXEL_BITWIDTH-1:0] HS_LO = PIXEL_BITWIDTH'(H_SYNC_START);
  localparam logic [PIXEL_BITWIDTH-1:0] HS_HI = PIXEL_BITWIDTH'(H_SYNC_END);
  localparam logic [PIXEL_BITWIDTH-1:0] VS_LO = PIXEL_BITWIDTH'(V_SYNC_START);
  localparam logic [PIXEL_BITWIDTH-1:0] VS_HI = PIXEL_BITWIDTH'(V_SYNC_END);
  localparam logic                      SYNC_IDLE = ~SYNC_ACTIVE;

  logic                      in_win;
  logic                      hsync_raw;
  logic                      vsync_raw;
  logic [PIXEL_BITWIDTH-1:0] x_rel;

  always_comb begin
    in_win    = i_visible && (i_x >= X_LO) && (i_x < X_HI) && (i_y < Y_VIS);
    x_rel     = i_x - X_LO;
    hsync_raw = (i_x >= HS_LO) && (i_x < HS_HI);
    vsync_raw = (i_y >= VS_LO) && (i_y < VS_HI);
  end

  // Stage 1: frame-buffer address; it only moves inside the window.
  logic s1_vis;
  logic s1_win;
  logic s1_hs;
  logic s1_vs;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fb_addr <= '0;
      o_fb_rd   <= 1'b0;
      s1_vis    <= 1'b0;
      s1_win    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else begin
      if (in_win) begin
        o_fb_addr <= {i_y[8:1], x_rel[8:1]};
      end
      o_fb_rd <= in_win;
      s1_vis  <= i_visible;
      s1_win  <= in_win;
      s1_hs   <= hsync_raw;
      s1_vs   <= vsync_raw;
    end
  end

  // Stage 2: palette index from frame buffer, or border colour outside window.
  logic       s2_vis;
  logic [5:0] s2_idx;
  logic       s2_hs;
  logic       s2_vs;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s2_vis <= 1'b0;
      s2_idx <= '0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
    end else begin
      s2_vis <= s1_vis;
      s2_idx <= s1_win ? i_fb_data : BORDER_INDEX;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
    end
  end

  logic [23:0] palette [64];

  always_ff @(posedge i_clk) begin
    if (i_pal_we) begin
      palette[i_pal_addr] <= i_pal_data;
    end
  end

  // Stage 3: colour and syncs leave together; the palette read sees pre-write data.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      {o_r, o_g, o_b} <= '0;
      o_hsync         <= SYNC_IDLE;
      o_vsync         <= SYNC_IDLE;
    end else begin
      {o_r, o_g, o_b} <= s2_vis ? palette[s2_idx] : '0;
      o_hsync         <= s2_hs ^ SYNC_IDLE;
      o_vsync         <= s2_vs ^ SYNC_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_vblank_start <= 1'b0;
    end else begin
      o_vblank_start <= (i_x == '0) && (i_y == Y_VIS);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{x_rel[0], x_rel[PIXEL_BITWIDTH-1:9], i_y[0], i_y[PIXEL_BITWIDTH-1:9]};

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Bench for vga_pixel_pipeline: reference model of pixel-to-colour rules,
// checked every cycle, plus literal expectations attached to directed vectors.
module tb_vga_pixel_pipeline;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic        vis = 1'b0;
  logic [15:0] fb_addr;
  logic        fb_rd;
  logic [5:0]  fb_data;
  logic        pal_we = 1'b0;
  logic [5:0]  pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, vblank_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pixel_pipeline #(.PIXEL_BITWIDTH(11), .X_OFFSET(64)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_x(x), .i_y(y), .i_visible(vis),
    .o_fb_addr(fb_addr), .o_fb_rd(fb_rd), .i_fb_data(fb_data),
    .i_pal_we(pal_we), .i_pal_addr(pal_addr), .i_pal_data(pal_data),
    .o_r(r), .o_g(g), .o_b(b), .o_hsync(hsync), .o_vsync(vsync),
    .o_vblank_start(vblank_start)
  );

  // Frame-buffer contents as a pure function of address; address 0 holds 0x21.
  function automatic logic [5:0] fb_func(input logic [15:0] a);
    int s;
    s = int'(a[15:8]) * 3 + int'(a[7:0]) + 33;
    return s[5:0];
  endfunction

  assign fb_data = fb_func(fb_addr);

  function automatic logic [23:0] pal_init(input int i);
    if (i == 'h21) return 24'h4C9AEC;
    if (i == 'h0F) return 24'h101010;
    return {8'(i * 4), 8'(255 - i), 8'(i ^ 'h5A)};
  endfunction

  // Literal expectations riding along with the current vector (-1 = none).
  int cur_la = -1, cur_lr = -1, cur_lrgb = -1, cur_lhs = -1, cur_lvs = -1, cur_lvb = -1;

  typedef struct {
    logic       vis;
    logic [5:0] idx;
    logic       hs_act;
    logic       vs_act;
    int         lrgb;
    int         lhs;
    int         lvs;
  } pix_t;

  function automatic pix_t blank();
    pix_t p;
    p.vis = 1'b0; p.idx = '0; p.hs_act = 1'b0; p.vs_act = 1'b0;
    p.lrgb = -1; p.lhs = -1; p.lvs = -1;
    return p;
  endfunction

  logic [23:0] pal [64];
  pix_t        q1, q2;
  logic [15:0] m_addr = '0;
  logic        m_rd = 1'b0;
  logic [23:0] m_rgb = '0;
  logic        m_hs = 1'b1, m_vs = 1'b1, m_vbs = 1'b0;
  int          l_a = -1, l_r = -1, l_vb = -1, l_rgb = -1, l_hs = -1, l_vs = -1;

  // Model: colour/sync of a pixel appear three edges after it is sampled;
  // address, read strobe and vblank pulse one edge after.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr = '0; m_rd = 1'b0; m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1; m_vbs = 1'b0;
      q1 = blank(); q2 = blank();
      l_a = -1; l_r = -1; l_vb = -1; l_rgb = -1; l_hs = -1; l_vs = -1;
    end else begin
      int xi, yi;
      logic win;
      logic [15:0] a;
      m_rgb = q2.vis ? pal[q2.idx] : 24'h0;
      m_hs  = !q2.hs_act;
      m_vs  = !q2.vs_act;
      l_rgb = q2.lrgb; l_hs = q2.lhs; l_vs = q2.lvs;
      q2 = q1;
      xi  = int'(x);
      yi  = int'(y);
      win = vis && xi >= 64 && xi < 576 && yi < 480;
      a   = {8'(yi / 2), 8'((xi - 64) / 2)};
      if (win) m_addr = a;
      m_rd      = win;
      m_vbs     = (xi == 0) && (yi == 480);
      q1.vis    = vis;
      q1.idx    = win ? fb_func(a) : 6'h0F;
      q1.hs_act = xi >= 656 && xi < 752;
      q1.vs_act = yi >= 490 && yi < 492;
      q1.lrgb = cur_lrgb; q1.lhs = cur_lhs; q1.lvs = cur_lvs;
      l_a = cur_la; l_r = cur_lr; l_vb = cur_lvb;
      if (pal_we) pal[pal_addr] = pal_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("fb_addr", 32'(fb_addr), 32'(m_addr));
    chk("fb_rd", 32'(fb_rd), 32'(m_rd));
    chk("rgb", 32'({r, g, b}), 32'(m_rgb));
    chk("hsync", 32'(hsync), 32'(m_hs));
    chk("vsync", 32'(vsync), 32'(m_vs));
    chk("vblank_start", 32'(vblank_start), 32'(m_vbs));
    if (l_a >= 0) chk("lit_fb_addr", 32'(fb_addr), l_a);
    if (l_r >= 0) chk("lit_fb_rd", 32'(fb_rd), l_r);
    if (l_vb >= 0) chk("lit_vblank_start", 32'(vblank_start), l_vb);
    if (l_rgb >= 0) chk("lit_rgb", 32'({r, g, b}), l_rgb);
    if (l_hs >= 0) chk("lit_hsync", 32'(hsync), l_hs);
    if (l_vs >= 0) chk("lit_vsync", 32'(vsync), l_vs);
    if (!rst_n) begin
      chk("rst_fb_addr", 32'(fb_addr), 0);
      chk("rst_fb_rd", 32'(fb_rd), 0);
      chk("rst_rgb", 32'({r, g, b}), 0);
      chk("rst_hsync", 32'(hsync), 1);
      chk("rst_vsync", 32'(vsync), 1);
      chk("rst_vblank_start", 32'(vblank_start), 0);
    end
  end

  task automatic px(input int xi, input int yi, input logic v,
                    input int la = -1, input int lr = -1, input int lrgb = -1,
                    input int lhs = -1, input int lvs = -1, input int lvb = -1);
    x = 11'(xi); y = 11'(yi); vis = v;
    cur_la = la; cur_lr = lr; cur_lrgb = lrgb; cur_lhs = lhs; cur_lvs = lvs; cur_lvb = lvb;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(700, 5, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      pal_we = 1'b1; pal_addr = 6'(i); pal_data = pal_init(i);
      px(700, 5, 1'b0);
    end
    pal_we = 1'b0;
    idle(3);

    px(64, 0, 1'b1, 'h0000, 1, 'h4C9AEC);
    px(575, 479, 1'b1, 'hEFFF);
    px(65, 1, 1'b1, 'h0000);
    px(10, 5, 1'b1, -1, 0, 'h101010);
    px(700, 5, 1'b0, -1, -1, 0);
    idle(3);

    for (int xs = 650; xs <= 760; xs++) begin
      int lh;
      lh = (xs == 655 || xs == 752) ? 1 : ((xs == 656 || xs == 751) ? 0 : -1);
      px(xs, 100, 1'b0, -1, -1, -1, lh);
    end
    for (int ys = 488; ys <= 493; ys++) begin
      int lv;
      lv = (ys == 490 || ys == 491) ? 0 : ((ys == 489 || ys == 492) ? 1 : -1);
      px(10, ys, 1'b0, -1, -1, -1, -1, lv);
    end
    idle(3);

    px(0, 480, 1'b0, -1, -1, -1, -1, -1, 1);
    px(1, 480, 1'b0, -1, -1, -1, -1, -1, 0);
    idle(3);

    // Pixel reads palette[0x21] on the same edge that rewrites it.
    px(64, 0, 1'b1, -1, -1, 'h4C9AEC);
    idle(1);
    pal_we = 1'b1; pal_addr = 6'h21; pal_data = 24'h123456;
    idle(1);
    pal_we = 1'b0;
    px(64, 0, 1'b1, -1, -1, 'h123456);
    idle(3);

    for (int ys = 2; ys <= 3; ys++)
      for (int xs = 60; xs <= 70; xs++) px(xs, ys, 1'b1);
    for (int ys = 478; ys <= 481; ys++)
      for (int xs = 570; xs <= 580; xs++) px(xs, ys, 1'b1);
    px(799, 10, 1'b0);
    px(0, 11, 1'b0);
    px(100, 11, 1'b1);
    idle(3);

    px(64, 2, 1'b1);
    px(66, 2, 1'b1);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    px(64, 0, 1'b1, -1, -1, 'h123456);
    idle(5);

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
